axi_stream_demux_2: RTL and testbench
=====================================

# axi_stream_demux_2

Packet-aware 1-to-2 AXI stream demultiplexer: routes one input stream to one of two output streams, selected by `address`. It is the splitting counterpart of the 2-to-1 stream mux and sits where a shared data path fans out to two consumers. The route is latched on the first beat of a packet and held until the `tlast` beat is accepted. Each output has a two-entry register slice, giving full throughput with no combinational path from output `ready` to input `ready`.

## Interface
Parameters:
- `DATA_WIDTH`, 16: width of `data` on all streams.
- `DEST_WIDTH`, 8: width of `dest`.
- `USER_WIDTH`, 8: width of `user`.

Ports:
- `clock`  in  1: single clock; all logic is posedge.
- `reset`  in  1: asynchronous, active-high reset.
- `address`  in  1: route select for the next packet (0 → `stream_out_1`, 1 → `stream_out_2`).
- `stream_in`  axi_stream.slave  —: input stream (`data`, `dest`, `user`, `tlast`, `valid`, `ready`).
- `stream_out_1`  axi_stream.master  —: output stream for route 0.
- `stream_out_2`  axi_stream.master  —: output stream for route 1.

## Operation
Route state:
- State `IDLE`: no packet in progress; effective select `sel = address`.
- State `LOCKED`: packet in progress; `sel = locked_sel`.
- Transition `IDLE`→`LOCKED` on an accepted beat with `tlast=0`; `locked_sel` ← `address`.
- Transition `LOCKED`→`IDLE` on an accepted beat with `tlast=1`.
- Single-beat packet (first beat has `tlast=1`): stay in `IDLE`.
- `address` changes while `LOCKED` are ignored until the packet ends.

Per-output slice (x = 1, 2):
- Registers: output register (`out_valid`, payload) and skid register (`skid_valid`, payload). Payload is `data`, `dest`, `user` and `tlast`, passed unmodified.
- `stream_in.ready = ~reset & ~skid_valid[sel]`.
- An input beat is accepted when `stream_in.valid & stream_in.ready`, and is routed to slice `sel`.
- If `~out_valid | stream_out_x.ready`: the output register loads the skid contents when `skid_valid` (skid then clears), else loads the accepted input beat. `out_valid` is 0 if nothing is loaded.
- Otherwise, an accepted input beat is written to the skid register.
- Skid overflow is impossible because input is accepted only when the skid is empty.
- The non-selected output keeps draining independently, so both outputs may hold valid data simultaneously.
- Beat order within each output is preserved. Beats are never dropped or duplicated.

## Timing
- Reset (async assert, sync release): all `out_valid`/`skid_valid` = 0, state `IDLE`, `locked_sel` = 0.
- While `reset` is high, both `stream_out_x.valid` and `stream_in.ready` are 0; other output payloads reset to 0.
- Reset mid-packet discards buffered beats and clears the lock.
- Latency: an accepted beat appears on its output on the next clock edge when that output is empty.
- Throughput: 1 beat/cycle per packet while the selected consumer holds `ready=1`.
- `stream_out_x.ready` low for N cycles: the selected slice accepts one more beat into the skid, then `stream_in.ready` drops.
- `stream_in.ready` depends only on registered state, `address` (in `IDLE`) and `reset`.
- Packet switch: the first beat of the next packet may be accepted in the cycle after the `tlast` beat.
- The new route may target a slice that is still full, stalling input without blocking the other output.

## Structure
- Package `axi_stream_demux_pkg`: `route_state_t` enum {`IDLE`, `LOCKED`}.
- Sub-module `axi_stream_skid_buffer` (parameters as above), instantiated once per output.
- Top level holds the route FSM, ready generation and valid steering.

## Test plan
- Reset with `stream_in.valid=1` → `ready=0`, both output `valid=0`. After release, `ready=1` next cycle.
- `address=0`, 4-beat packet `data` 0x10..0x13 (`tlast` on 0x13), outputs always ready → `stream_out_1` emits 0x10..0x13 on 4 consecutive cycles, 1 cycle after input; `stream_out_2.valid` stays 0.
- `address` toggled to 1 after the first beat of an 8-beat packet → all 8 beats on `stream_out_1`. The next packet goes to `stream_out_2`.
- `stream_out_1.ready=0` for 5 cycles during a packet → exactly 2 beats buffered, then `stream_in.ready=0`. Release delivers all beats in order, with no loss.
- Single-beat packets alternating `address` 0/1/0/1 with `tlast=1`, `data` 0xA0..0xA3 → 0xA0, 0xA2 on out_1 and 0xA1, 0xA3 on out_2, at 1 beat/cycle.
- Async reset asserted mid-packet with both slices full → valids clear immediately. A post-reset packet with `address=1` is routed to out_2.

Source files
------------

// File: rtl/axi_stream_demux_pkg.sv
// Shared types and helpers for the packet-aware 1-to-2 AXI stream demultiplexer.
// The route state tells whether a packet is in flight and its route is pinned.
package axi_stream_demux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } route_state_t;

    localparam int NUM_OUTPUTS = 2;

    // Inside a packet the latched route wins; between packets the live address does.
    function automatic logic effective_sel(
        input route_state_t state,
        input logic         locked_sel,
        input logic         address
    );
        return (state == LOCKED) ? locked_sel : address;
    endfunction

endpackage

// File: rtl/axi_stream.sv
// AXI stream bundle: payload (data/dest/user/tlast) plus valid/ready.
// A beat transfers on a rising clock edge where valid and ready are both high;
// a master never withdraws valid or alters the payload until that transfer happens.
interface axi_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic [USER_WIDTH-1:0] user;
    logic                  tlast;
    logic                  valid;
    logic                  ready;

    modport master (
        output data,
        output dest,
        output user,
        output tlast,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  dest,
        input  user,
        input  tlast,
        input  valid,
        output ready
    );
endinterface

// File: rtl/axi_stream_skid_buffer.sv
// Two-entry register slice for one demux output: an output register plus a skid
// register that catches the one beat accepted in the cycle the consumer stalls.
module axi_stream_skid_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic [DEST_WIDTH-1:0] in_dest_i,
    input  logic [USER_WIDTH-1:0] in_user_i,
    input  logic                  in_last_i,
    output logic                  skid_valid_o,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [DEST_WIDTH-1:0] out_dest_o,
    output logic [USER_WIDTH-1:0] out_user_o,
    output logic                  out_last_o,
    input  logic                  out_ready_i
);

    localparam int PW = DATA_WIDTH + DEST_WIDTH + USER_WIDTH + 1;

    logic [PW-1:0] in_payload;
    logic [PW-1:0] out_payload_q, out_payload_d;
    logic [PW-1:0] skid_payload_q, skid_payload_d;
    logic          out_valid_q, out_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic          out_free;

    assign in_payload = {in_data_i, in_dest_i, in_user_i, in_last_i};
    assign out_free   = ~out_valid_q | out_ready_i;

    // in_valid_i is only ever raised while the skid is empty, so the skid
    // cannot be overwritten and a draining skid never competes with new input.
    always_comb begin
        out_valid_d    = out_valid_q;
        out_payload_d  = out_payload_q;
        skid_valid_d   = skid_valid_q;
        skid_payload_d = skid_payload_q;
        if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d   = 1'b1;
                out_payload_d = skid_payload_q;
                skid_valid_d  = 1'b0;
            end else begin
                out_valid_d = in_valid_i;
                if (in_valid_i) begin
                    out_payload_d = in_payload;
                end
            end
        end else if (in_valid_i) begin
            skid_valid_d   = 1'b1;
            skid_payload_d = in_payload;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q    <= 1'b0;
            out_payload_q  <= '0;
            skid_valid_q   <= 1'b0;
            skid_payload_q <= '0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_payload_q  <= out_payload_d;
            skid_valid_q   <= skid_valid_d;
            skid_payload_q <= skid_payload_d;
        end
    end

    assign skid_valid_o = skid_valid_q;
    assign out_valid_o  = out_valid_q;
    assign {out_data_o, out_dest_o, out_user_o, out_last_o} = out_payload_q;

endmodule

// File: rtl/axi_stream_demux_2.sv
// Packet-aware 1-to-2 AXI stream demux: the route is pinned on a packet's first
// beat and held until its tlast beat is accepted; each output has its own slice.
module axi_stream_demux_2
    import axi_stream_demux_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 8
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      address,
    axi_stream.slave  stream_in,
    axi_stream.master stream_out_1,
    axi_stream.master stream_out_2
);

    route_state_t state_q, state_d;
    logic         locked_sel_q, locked_sel_d;
    logic         sel;
    logic         in_ready;
    logic         accept;

    logic [NUM_OUTPUTS-1:0] skid_valid;
    logic [NUM_OUTPUTS-1:0] slice_in_valid;

    assign sel = effective_sel(state_q, locked_sel_q, address);

    // Ready looks only at the selected skid flag, never at downstream ready,
    // so there is no combinational path from an output back to the input.
    assign in_ready        = ~reset & ~skid_valid[sel];
    assign stream_in.ready = in_ready;
    assign accept          = stream_in.valid & in_ready;

    assign slice_in_valid[0] = accept & (sel == 1'b0);
    assign slice_in_valid[1] = accept & (sel == 1'b1);

    always_comb begin
        state_d      = state_q;
        locked_sel_d = locked_sel_q;
        case (state_q)
            IDLE: begin
                if (accept && !stream_in.tlast) begin
                    state_d      = LOCKED;
                    locked_sel_d = address;
                end
            end
            LOCKED: begin
                if (accept && stream_in.tlast) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            locked_sel_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            locked_sel_q <= locked_sel_d;
        end
    end

    axi_stream_skid_buffer #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEST_WIDTH(DEST_WIDTH),
        .USER_WIDTH(USER_WIDTH)
    ) u_slice_1 (
        .clock       (clock),
        .reset       (reset),
        .in_valid_i  (slice_in_valid[0]),
        .in_data_i   (stream_in.data),
        .in_dest_i   (stream_in.dest),
        .in_user_i   (stream_in.user),
        .in_last_i   (stream_in.tlast),
        .skid_valid_o(skid_valid[0]),
        .out_valid_o (stream_out_1.valid),
        .out_data_o  (stream_out_1.data),
        .out_dest_o  (stream_out_1.dest),
        .out_user_o  (stream_out_1.user),
        .out_last_o  (stream_out_1.tlast),
        .out_ready_i (stream_out_1.ready)
    );

    axi_stream_skid_buffer #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEST_WIDTH(DEST_WIDTH),
        .USER_WIDTH(USER_WIDTH)
    ) u_slice_2 (
        .clock       (clock),
        .reset       (reset),
        .in_valid_i  (slice_in_valid[1]),
        .in_data_i   (stream_in.data),
        .in_dest_i   (stream_in.dest),
        .in_user_i   (stream_in.user),
        .in_last_i   (stream_in.tlast),
        .skid_valid_o(skid_valid[1]),
        .out_valid_o (stream_out_2.valid),
        .out_data_o  (stream_out_2.data),
        .out_dest_o  (stream_out_2.dest),
        .out_user_o  (stream_out_2.user),
        .out_last_o  (stream_out_2.tlast),
        .out_ready_i (stream_out_2.ready)
    );

endmodule

// File: tb/tb_axi_stream_demux_2.sv
// Directed bench for axi_stream_demux_2: drivers push expected beats per output,
// a negedge monitor pops and compares whatever each output hands over.
module tb_axi_stream_demux_2;

    localparam int DW = 16;
    localparam int TW = 8;
    localparam int UW = 8;
    localparam int PW = DW + TW + UW + 1;

    logic clock = 1'b0;
    logic reset;
    logic address;
    int   cyc = 0;

    axi_stream #(.DATA_WIDTH(DW), .DEST_WIDTH(TW), .USER_WIDTH(UW)) s_in ();
    axi_stream #(.DATA_WIDTH(DW), .DEST_WIDTH(TW), .USER_WIDTH(UW)) s_o1 ();
    axi_stream #(.DATA_WIDTH(DW), .DEST_WIDTH(TW), .USER_WIDTH(UW)) s_o2 ();

    axi_stream_demux_2 #(
        .DATA_WIDTH(DW),
        .DEST_WIDTH(TW),
        .USER_WIDTH(UW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .address     (address),
        .stream_in   (s_in),
        .stream_out_1(s_o1),
        .stream_out_2(s_o2)
    );

    // clock / reset
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    logic [PW-1:0] exp_q1[$];
    logic [PW-1:0] exp_q2[$];
    int            acc_cyc[$];
    int            emit1_cyc[$];
    int            emit2_cyc[$];
    int            n_acc   = 0;
    int            n_check = 0;
    int            n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_check++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor
    always @(negedge clock) begin
        if (s_o1.valid && s_o1.ready) begin
            if (exp_q1.size() == 0) begin
                n_check++;
                n_fail++;
                $display("FAIL out1_unexpected: got beat data 0x%0h, expected none", s_o1.data);
            end else begin
                check("out1_beat", {s_o1.data, s_o1.dest, s_o1.user, s_o1.tlast}, exp_q1.pop_front());
                emit1_cyc.push_back(cyc);
            end
        end
        if (s_o2.valid && s_o2.ready) begin
            if (exp_q2.size() == 0) begin
                n_check++;
                n_fail++;
                $display("FAIL out2_unexpected: got beat data 0x%0h, expected none", s_o2.data);
            end else begin
                check("out2_beat", {s_o2.data, s_o2.dest, s_o2.user, s_o2.tlast}, exp_q2.pop_front());
                emit2_cyc.push_back(cyc);
            end
        end
    end

    // driver tasks
    task automatic send(input logic addr, input logic [DW-1:0] data, input logic last, input int exp_port);
        int  t;
        bit  done;
        logic [PW-1:0] beat;
        t    = 0;
        done = 1'b0;
        address     = addr;
        s_in.data   = data;
        s_in.dest   = data[7:0] ^ 8'h5A;
        s_in.user   = ~data[7:0];
        s_in.tlast  = last;
        s_in.valid  = 1'b1;
        beat = {data, data[7:0] ^ 8'h5A, ~data[7:0], last};
        while (!done) begin
            @(negedge clock);
            if (s_in.ready) begin
                if (exp_port == 1) exp_q1.push_back(beat);
                else               exp_q2.push_back(beat);
                acc_cyc.push_back(cyc);
                n_acc++;
                done = 1'b1;
            end else if (++t > 100) begin
                n_check++;
                n_fail++;
                $display("FAIL send_timeout: data 0x%0h not accepted in 100 cycles", data);
                done = 1'b1;
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic idle(input int n);
        s_in.valid = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_logs();
        acc_cyc.delete();
        emit1_cyc.delete();
        emit2_cyc.delete();
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_q1_left"}, exp_q1.size(), 0);
        check({tag, "_q2_left"}, exp_q2.size(), 0);
    endtask

    int acc_before;

    initial begin
        reset       = 1'b1;
        address     = 1'b0;
        s_in.valid  = 1'b1;
        s_in.data   = 16'h1234;
        s_in.dest   = '0;
        s_in.user   = '0;
        s_in.tlast  = 1'b0;
        s_o1.ready  = 1'b1;
        s_o2.ready  = 1'b1;

        // reset with valid high
        #2;
        check("rst_in_ready", s_in.ready, 0);
        check("rst_out1_valid", s_o1.valid, 0);
        check("rst_out2_valid", s_o2.valid, 0);
        repeat (3) @(posedge clock);
        #1;
        check("rst_in_ready_held", s_in.ready, 0);
        s_in.valid = 1'b0;
        reset      = 1'b0;
        @(negedge clock);
        check("post_rst_in_ready", s_in.ready, 1);
        @(posedge clock);
        #1;

        // 4-beat packet to out_1, latency 1, 1 beat/cycle
        clear_logs();
        for (int i = 0; i < 4; i++) send(1'b0, 16'h0010 + 16'(i), (i == 3), 1);
        idle(4);
        check("p4_out1_count", emit1_cyc.size(), 4);
        check("p4_out2_count", emit2_cyc.size(), 0);
        if (emit1_cyc.size() == 4 && acc_cyc.size() == 4) begin
            for (int i = 0; i < 4; i++) check("p4_latency", emit1_cyc[i] - acc_cyc[i], 1);
            check("p4_throughput", acc_cyc[3] - acc_cyc[0], 3);
        end
        check_drained("p4");

        // address toggled mid-packet is ignored; next packet goes to out_2
        clear_logs();
        for (int i = 0; i < 8; i++) send((i != 0), 16'h0020 + 16'(i), (i == 7), 1);
        send(1'b1, 16'h0030, 1'b0, 2);
        send(1'b0, 16'h0031, 1'b1, 2);
        idle(4);
        check("lock_out1_count", emit1_cyc.size(), 8);
        check("lock_out2_count", emit2_cyc.size(), 2);
        check_drained("lock");

        // out_1 stalled 5 cycles: two beats buffered then input stalls
        clear_logs();
        s_o1.ready = 1'b0;
        acc_before = n_acc;
        fork
            begin
                for (int i = 0; i < 6; i++) send(1'b0, 16'h0040 + 16'(i), (i == 5), 1);
            end
            begin
                repeat (5) @(negedge clock);
                check("stall_buffered", n_acc - acc_before, 2);
                check("stall_in_ready", s_in.ready, 0);
                @(posedge clock);
                #1;
                s_o1.ready = 1'b1;
            end
        join
        idle(5);
        check("stall_out1_count", emit1_cyc.size(), 6);
        check_drained("stall");

        // single-beat packets alternating routes at full rate
        clear_logs();
        for (int i = 0; i < 4; i++) send(i[0], 16'h00A0 + 16'(i), 1'b1, (i % 2 == 0) ? 1 : 2);
        idle(4);
        check("single_out1_count", emit1_cyc.size(), 2);
        check("single_out2_count", emit2_cyc.size(), 2);
        if (acc_cyc.size() == 4) check("single_throughput", acc_cyc[3] - acc_cyc[0], 3);
        check_drained("single");

        // async reset with both slices full
        s_o2.ready = 1'b0;
        send(1'b1, 16'h00B0, 1'b1, 2);
        send(1'b1, 16'h00B1, 1'b1, 2);
        s_o1.ready = 1'b0;
        send(1'b0, 16'h00C0, 1'b0, 1);
        send(1'b0, 16'h00C1, 1'b0, 1);
        s_in.valid = 1'b0;
        @(negedge clock);
        check("full_out1_valid", s_o1.valid, 1);
        check("full_out2_valid", s_o2.valid, 1);
        check("full_in_ready", s_in.ready, 0);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_out1_valid", s_o1.valid, 0);
        check("async_rst_out2_valid", s_o2.valid, 0);
        check("async_rst_in_ready", s_in.ready, 0);
        exp_q1.delete();
        exp_q2.delete();
        @(posedge clock);
        #1;
        reset      = 1'b0;
        s_o1.ready = 1'b1;
        s_o2.ready = 1'b1;
        clear_logs();
        send(1'b1, 16'h00D0, 1'b0, 2);
        send(1'b0, 16'h00D1, 1'b1, 2);
        idle(4);
        check("post_rst_out2_count", emit2_cyc.size(), 2);
        check("post_rst_out1_count", emit1_cyc.size(), 0);
        check_drained("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule
